// File: rtl/wb_ps2_keyboard_if.sv
// rtl/wb_ps2_keyboard_if.sv - Wishbone slave bus bundle for the PS/2 keyboard port
interface wb_ps2_keyboard_if;
   logic [5:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/wb_ps2_keyboard.sv
// rtl/wb_ps2_keyboard.sv - PS/2 keyboard receiver with scan-code FIFO behind a Wishbone slave
module wb_ps2_keyboard #(
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 50000
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n_i,
   wb_ps2_keyboard_if.slave   bus,
   input  logic               ps2_clk_i,
   input  logic               ps2_data_i,
   output logic               irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} rx_state_t;

   rx_state_t   state_q, state_d;
   logic [2:0]  clk_sync;
   logic [1:0]  dat_sync;
   logic        ps2_fall, ps2_bit;
   logic [9:0]  shift_q;
   logic [3:0]  bitcnt_q;
   logic [TW-1:0] to_cnt_q;

   logic        push_req, parity_set, frame_set, to_expire;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic        not_empty, full, do_push, pop;
   logic [7:0]  count8;

   logic        ovf_q, par_err_q, frm_err_q;
   logic        rx_en_q, irq_en_q;
   logic        ack_q, irq_q;
   logic [31:0] dat_q, rdata;
   logic        access, rd, wr, clr;
   logic [3:0]  reg_sel;
   logic        unused_bits;

   // Idle-high reset value keeps reset release from looking like a falling edge.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         clk_sync <= 3'b111;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk_i};
         dat_sync <= {dat_sync[0], ps2_data_i};
      end
   end

   assign ps2_fall = clk_sync[2] & ~clk_sync[1];
   assign ps2_bit  = dat_sync[1];

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      to_expire  = 1'b0;
      push_req   = 1'b0;
      parity_set = 1'b0;
      frame_set  = 1'b0;
      case (state_q)
         ST_IDLE: if (ps2_fall && !ps2_bit) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (ps2_fall) begin
               if (bitcnt_q == 4'd9) state_d = ST_CHECK;
            end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
               to_expire = rx_en_q;
               state_d   = ST_IDLE;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (rx_en_q) begin
               if (!shift_q[9])         frame_set  = 1'b1;
               else if (!(^shift_q[8:0])) parity_set = 1'b1;
               else                     push_req   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (to_expire) frame_set = 1'b1;
      if (!rx_en_q) state_d = ST_IDLE;
   end

   // Start bit is consumed in IDLE; shift_q ends as {stop, parity, data[7:0]}.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         shift_q  <= '0;
         bitcnt_q <= '0;
         to_cnt_q <= '0;
      end else if (state_q != ST_SHIFT) begin
         bitcnt_q <= '0;
         to_cnt_q <= '0;
      end else if (ps2_fall) begin
         shift_q  <= {ps2_bit, shift_q[9:1]};
         bitcnt_q <= bitcnt_q + 4'd1;
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   assign access  = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
   assign rd      = access & ~bus.wb_we_i;
   assign wr      = access & bus.wb_we_i;
   assign reg_sel = bus.wb_adr_i[5:2];
   assign clr     = wr & bus.wb_sel_i[0] & (reg_sel == 4'd1);

   assign not_empty = (count_q != '0);
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign pop       = rd & (reg_sel == 4'd0) & not_empty;
   assign do_push   = push_req & (~full | pop);
   assign count8    = 8'(count_q);

   always_ff @(posedge wb_clk_i) begin
      if (do_push) mem[wr_ptr_q] <= shift_q[7:0];
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(pop);
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         4'd0: if (not_empty) rdata = {23'd0, 1'b1, mem[rd_ptr_q]};
         4'd1: rdata = {16'd0, count8, 3'd0, frm_err_q, par_err_q, ovf_q, full, not_empty};
         4'd2: rdata = {30'd0, irq_en_q, rx_en_q};
         default: rdata = '0;
      endcase
   end

   // A flag raised in the same cycle as a clearing write stays set.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ovf_q     <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         rx_en_q   <= 1'b0;
         irq_en_q  <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         ovf_q     <= (push_req & full & ~pop) | (ovf_q & ~(clr & bus.wb_dat_i[2]));
         par_err_q <= parity_set | (par_err_q & ~(clr & bus.wb_dat_i[3]));
         frm_err_q <= frame_set | (frm_err_q & ~(clr & bus.wb_dat_i[4]));
         if (wr && bus.wb_sel_i[0] && reg_sel == 4'd2) begin
            rx_en_q  <= bus.wb_dat_i[0];
            irq_en_q <= bus.wb_dat_i[1];
         end
         ack_q <= access;
         dat_q <= rd ? rdata : '0;
         irq_q <= irq_en_q & not_empty;
      end
   end

   assign bus.wb_ack_o = ack_q;
   assign bus.wb_dat_o = dat_q;
   assign bus.wb_err_o = 1'b0;
   assign bus.wb_rty_o = 1'b0;
   assign irq_o        = irq_q;

   assign unused_bits = ^{bus.wb_dat_i[31:5], bus.wb_sel_i[3:1], bus.wb_adr_i[1:0],
                          bus.wb_cti_i, bus.wb_bte_i};

endmodule

// File: tb/tb_wb_ps2_keyboard.sv
// tb/tb_wb_ps2_keyboard.sv - directed self-checking bench for wb_ps2_keyboard
module tb_wb_ps2_keyboard;
   localparam int DEPTH = 16;
   localparam int TOUT  = 300;
   localparam int HALF  = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic irq;
   int   total = 0;
   int   bad = 0;

   wb_ps2_keyboard_if bus();

   wb_ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .bus        (bus),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_read(input logic [5:0] adr, output logic [31:0] d);
      logic ok;
      ok = 1'b0;
      d = '0;
      bus.wb_adr_i = adr;
      bus.wb_we_i = 1'b0;
      bus.wb_sel_i = 4'hF;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (bus.wb_ack_o === 1'b1) begin
            ok = 1'b1;
            d = bus.wb_dat_o;
            total++;
            if ({bus.wb_err_o, bus.wb_rty_o} !== 2'b00) begin
               bad++;
               $display("FAIL err_rty: got %b want 00", {bus.wb_err_o, bus.wb_rty_o});
            end
         end
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL read_ack_timeout: got no ack want ack adr=%h", adr);
      end
   endtask

   task automatic wb_write(input logic [5:0] adr, input logic [31:0] d, input logic [3:0] sel);
      logic ok;
      ok = 1'b0;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = d;
      bus.wb_we_i = 1'b1;
      bus.wb_sel_i = sel;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (bus.wb_ack_o === 1'b1) ok = 1'b1;
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL write_ack_timeout: got no ack want ack adr=%h", adr);
      end
   endtask

   task automatic ps2_send_bit(input logic b);
      ps2_data = b;
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   // Sends the first n bits of a frame: start, data LSB first, parity, stop.
   task automatic ps2_send(input logic [7:0] d, input logic good_par, input int n);
      logic [10:0] bits;
      logic        par;
      par = good_par ? ~(^d) : ^d;
      bits = {1'b1, par, d, 1'b0};
      for (int i = 0; i < n; i++) ps2_send_bit(bits[i]);
      ps2_data = 1'b1;
      cycles(HALF);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst_n = 1'b0;
      cycles(3);
      total++;
      if ({bus.wb_ack_o, irq} !== 2'b00 || bus.wb_dat_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: got ack=%b irq=%b dat=%h want 0 0 0", bus.wb_ack_o, irq, bus.wb_dat_o);
      end
      rst_n = 1'b1;
      cycles(2);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", d); end
      wb_read(6'h08, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", d); end
   endtask

   task automatic test_single;
      logic [31:0] d;
      wb_write(6'h08, 32'h1, 4'h1);
      ps2_send(8'h1C, 1'b1, 11);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0101) begin bad++; $display("FAIL single_status: got %h want 0101", d); end
      wb_read(6'h00, d);
      total++;
      if (d !== 32'h11C) begin bad++; $display("FAIL single_data: got %h want 11c", d); end
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL single_status_after: got %h want 0", d); end
      wb_read(6'h00, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL empty_data: got %h want 0", d); end
   endtask

   task automatic test_parity;
      logic [31:0] d;
      ps2_send(8'h1C, 1'b0, 11);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h08) begin bad++; $display("FAIL parity_status: got %h want 08", d); end
      wb_write(6'h04, 32'h08, 4'h0);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h08) begin bad++; $display("FAIL parity_sel0_clear: got %h want 08", d); end
      wb_write(6'h04, 32'h08, 4'h1);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL parity_clear: got %h want 0", d); end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      for (int i = 0; i <= DEPTH; i++) ps2_send(8'(i), 1'b1, 11);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h1007) begin bad++; $display("FAIL ovf_status: got %h want 1007", d); end
      for (int i = 0; i < DEPTH; i++) begin
         wb_read(6'h00, d);
         total++;
         if (d !== 32'h100 + 32'(i)) begin
            bad++;
            $display("FAIL ovf_data[%0d]: got %h want %h", i, d, 32'h100 + 32'(i));
         end
      end
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h04) begin bad++; $display("FAIL ovf_sticky: got %h want 04", d); end
      wb_write(6'h04, 32'h04, 4'h1);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL ovf_clear: got %h want 0", d); end
   endtask

   task automatic test_irq;
      logic [31:0] d;
      wb_write(6'h08, 32'h3, 4'h1);
      cycles(2);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle: got %b want 0", irq); end
      ps2_send(8'h5A, 1'b1, 11);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
      wb_read(6'h00, d);
      total++;
      if (d !== 32'h15A) begin bad++; $display("FAIL irq_data: got %h want 15a", d); end
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_at_ack: got %b want 1", irq); end
      cycles(1);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
   endtask

   task automatic test_timeout;
      logic [31:0] d;
      wb_write(6'h08, 32'h1, 4'h1);
      ps2_send(8'hFF, 1'b1, 4);
      cycles(TOUT / 2);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL timeout_early: got %h want 0", d); end
      cycles(TOUT);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h10) begin bad++; $display("FAIL timeout_frame_err: got %h want 10", d); end
      wb_write(6'h04, 32'h10, 4'h1);
      ps2_send(8'hA5, 1'b1, 11);
      wb_read(6'h00, d);
      total++;
      if (d !== 32'h1A5) begin bad++; $display("FAIL timeout_recover: got %h want 1a5", d); end
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL timeout_status: got %h want 0", d); end
   endtask

   task automatic test_rx_disable;
      logic [31:0] d;
      wb_write(6'h08, 32'h0, 4'h1);
      ps2_send(8'h42, 1'b1, 11);
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL rxdis_status: got %h want 0", d); end
      wb_write(6'h08, 32'h1, 4'h1);
      ps2_send(8'h77, 1'b1, 5);
      wb_write(6'h08, 32'h0, 4'h1);
      wb_write(6'h08, 32'h1, 4'h1);
      ps2_send(8'h24, 1'b1, 11);
      wb_read(6'h00, d);
      total++;
      if (d !== 32'h124) begin bad++; $display("FAIL rxdis_abort_data: got %h want 124", d); end
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL rxdis_abort_status: got %h want 0", d); end
   endtask

   task automatic test_back_to_back;
      int acks;
      acks = 0;
      bus.wb_adr_i = 6'h04;
      bus.wb_we_i = 1'b0;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.wb_ack_o === 1'b1) acks++;
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      total++;
      if (acks !== 2) begin bad++; $display("FAIL held_strobe_acks: got %0d want 2", acks); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] d;
      wb_write(6'h08, 32'h3, 4'h1);
      ps2_send(8'h33, 1'b1, 11);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_before: got %b want 1", irq); end
      ps2_send(8'h81, 1'b1, 3);
      ps2_clk = 1'b0;
      bus.wb_adr_i = 6'h04;
      bus.wb_we_i = 1'b0;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.wb_ack_o !== 1'b1) begin bad++; $display("FAIL mid_ack_before: got %b want 1", bus.wb_ack_o); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.wb_ack_o, irq} !== 2'b00 || bus.wb_dat_o !== 32'd0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got ack=%b irq=%b dat=%h want 0 0 0", bus.wb_ack_o, irq, bus.wb_dat_o);
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      wb_read(6'h14, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want 0", d); end
      cycles(1);
      total++;
      if (bus.wb_ack_o !== 1'b0) begin bad++; $display("FAIL single_cycle_ack: got %b want 0", bus.wb_ack_o); end
      wb_read(6'h04, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_status_after: got %h want 0", d); end
      wb_read(6'h08, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_ctrl_after: got %h want 0", d); end
   endtask

   initial begin
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_cti_i = '0;
      bus.wb_bte_i = '0;
      test_reset;
      test_single;
      test_parity;
      test_overflow;
      test_irq;
      test_timeout;
      test_rx_disable;
      test_back_to_back;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
